// File: rtl/alu_cmd_engine_if.sv
// alu_cmd_engine_if: command, response and ALU-drive bundle; slave = engine view, master = issuer/ALU view
interface alu_cmd_engine_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_f;
    logic [WIDTH-1:0] alu_s;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_s,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_f
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_s,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_a, alu_b, alu_f
    );
endinterface

// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: sequences one command at a time through an external combinational ALU.
// Ports: clk, rst_n (async active-low); bus (slave) carries cmd valid/ready + op/a/b,
// rsp valid/ready + data/zero/err, and the ALU drive alu_a/alu_b/alu_f with result alu_s.
module alu_cmd_engine #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_cmd_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [SHAMT_W-1:0] n;
    logic               accept;
    logic               illegal;
    logic               shift;

    assign n       = bus.cmd_b[SHAMT_W-1:0];
    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign illegal = bus.cmd_op[4:3] != 2'b00;
    assign shift   = bus.cmd_op[4:1] == 4'd3;

    // The registered alu_a doubles as the shift accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_f     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.cmd_ready <= !accept;
                    if (accept) begin
                        bus.rsp_err <= illegal;
                        if (!illegal && (!shift || n != '0)) begin
                            state     <= shift ? SHIFT : EXEC;
                            bus.alu_a <= bus.cmd_a;
                            bus.alu_b <= shift ? '0 : bus.cmd_b;
                            bus.alu_f <= bus.cmd_op;
                            cnt       <= n;
                        end else begin
                            // Zero-count shift or illegal op answers straight away.
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= illegal ? '0 : bus.cmd_a;
                            bus.rsp_zero  <= illegal || bus.cmd_a == WIDTH'(0);
                        end
                    end
                end
                EXEC, SHIFT: begin
                    cnt       <= cnt - 1'b1;
                    bus.alu_a <= bus.alu_s;
                    if (state == EXEC || cnt == SHAMT_W'(1)) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= bus.alu_s;
                        bus.rsp_zero  <= bus.alu_s == WIDTH'(0);
                        bus.alu_a     <= '0;
                        bus.alu_b     <= '0;
                        bus.alu_f     <= '0;
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
